// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Purpose: turns the load-use stall request and the EX branch-taken signal
// into the write enables, IF/ID flush and ID/EX bubble controls of a simple
// in-order pipeline. Supports multi-cycle load-use stalls (STALL_CYCLES) and
// a global freeze while data memory is not ready (mem_wait).
//
// Optional feature macro: STALL_PERF_CNT_EN
//   defined   -> stall_count / flush_count saturating performance counters
//   undefined -> counter ports and logic are absent
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst_n        asynchronous active-low reset
//   stall_req    load-use hazard request
//   branch_taken branch/jump resolved taken in EX
//   mem_wait     data memory not ready, freezes everything
//   pc_write     PC write enable
//   if_id_write  IF/ID write enable
//   if_id_flush  IF/ID loads a NOP
//   id_ex_bubble ID/EX control fields forced to zero
//   id_ex_write  ID/EX write enable
//   busy         high while in the STALL state
//   stall_count  bubble-only cycles counted (STALL_PERF_CNT_EN)
//   flush_count  flush cycles counted (STALL_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_write,
    output logic             busy
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Elaboration-time guard on the parameter ranges the rem counter can hold.
    if (STALL_CYCLES < 1 || STALL_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
        $error("pipeline_stall_controller: illegal STALL_CYCLES or CNT_W");
    end

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;

    // State register: FSM state and remaining stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic: mem_wait freezes, branch aborts, otherwise stall sequencing.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (mem_wait) begin
            state_d = state_q;
            rem_d   = rem_q;
        end else if (branch_taken) begin
            state_d = ST_RUN;
            rem_d   = 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // A single-cycle stall is fully served by the RUN cycle itself.
                    if (stall_req && (STALL_CYCLES > 1)) begin
                        state_d = ST_STALL;
                        rem_d   = 4'(STALL_CYCLES - 1);
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = 4'd0;
                    end
                end
                ST_STALL: begin
                    if (rem_q <= 4'd1) begin
                        state_d = ST_RUN;
                        rem_d   = 4'd0;
                    end else begin
                        state_d = ST_STALL;
                        rem_d   = rem_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 4'd0;
                end
            endcase
        end
    end

    // Output logic: combinational so a request takes effect in the same cycle;
    // reset forces the RUN-idle values regardless of the inputs.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_write  = 1'b1;
        busy         = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            busy = (state_q == ST_STALL);
            if (mem_wait) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_write = 1'b0;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if ((state_q == ST_STALL) || stall_req) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counter next values: saturating, and idle while memory freezes the pipe.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (mem_wait) begin
            stall_count_d = stall_count_q;
            flush_count_d = flush_count_q;
        end else begin
            if (id_ex_bubble && !if_id_flush && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_count_d = stall_count_q;
            end
            if (if_id_flush && (flush_count_q != CNT_MAX)) begin
                flush_count_d = flush_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_count_d = flush_count_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= {CNT_W{1'b0}};
            flush_count_q <= {CNT_W{1'b0}};
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: two instances (STALL_CYCLES=1 and 3) share inputs;
// a behavioural model pushes expected outputs into a scoreboard queue when
// stimulus is driven, and they are popped and compared after settling.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst_n, stall_req, branch_taken, mem_wait;
    logic pcw1, ifw1, fl1, bub1, exw1, busy1;
    logic pcw3, ifw3, fl3, bub3, exw3, busy3;
`ifdef STALL_PERF_CNT_EN
    logic [15:0] scnt1, fcnt1, scnt3, fcnt3;
`endif

    always #5 clk = ~clk;

    pipeline_stall_controller #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(fl1),
        .id_ex_bubble(bub1), .id_ex_write(exw1), .busy(busy1)
`ifdef STALL_PERF_CNT_EN
        , .stall_count(scnt1), .flush_count(fcnt1)
`endif
    );

    pipeline_stall_controller #(.STALL_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .pc_write(pcw3), .if_id_write(ifw3), .if_id_flush(fl3),
        .id_ex_bubble(bub3), .id_ex_write(exw3), .busy(busy3)
`ifdef STALL_PERF_CNT_EN
        , .stall_count(scnt3), .flush_count(fcnt3)
`endif
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write, busy}
    typedef struct {
        logic [5:0] o1;
        logic [5:0] o3;
        int         sc1, fc1, sc3, fc3;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   left1 = 0, left3 = 0;        // bubble cycles still owed after this one
    int   m_sc1 = 0, m_fc1 = 0, m_sc3 = 0, m_fc3 = 0;
    localparam logic [5:0] IDLE = 6'b110010;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_out(int left, logic mw, logic bt, logic sr);
        if (mw)            return {5'b00000, 1'(left > 0)};
        else if (bt)       return {5'b11111, 1'(left > 0)};
        else if (left > 0) return 6'b000111;
        else if (sr)       return 6'b000110;
        else               return IDLE;
    endfunction

    function automatic int model_next(int left, int sc, logic mw, logic bt, logic sr);
        if (mw)            return left;
        else if (bt)       return 0;
        else if (left > 0) return left - 1;
        else if (sr)       return sc - 1;
        else               return 0;
    endfunction

    function automatic int cnt_upd(int c, logic inc);
        if (inc && c < 65535) return c + 1;
        else                  return c;
    endfunction

    // One clock cycle: drive, push expectation, settle, pop and compare, advance model.
    task automatic cyc(input logic mw, input logic bt, input logic sr);
        exp_t e, g;
        @(negedge clk);
        mem_wait = mw; branch_taken = bt; stall_req = sr;
        e.o1 = model_out(left1, mw, bt, sr);
        e.o3 = model_out(left3, mw, bt, sr);
        e.sc1 = m_sc1; e.fc1 = m_fc1; e.sc3 = m_sc3; e.fc3 = m_fc3;
        exp_q.push_back(e);
        #2;
        g = exp_q.pop_front();
        check_eq("out_sc1", {26'd0, pcw1, ifw1, fl1, bub1, exw1, busy1}, {26'd0, g.o1});
        check_eq("out_sc3", {26'd0, pcw3, ifw3, fl3, bub3, exw3, busy3}, {26'd0, g.o3});
`ifdef STALL_PERF_CNT_EN
        check_eq("stall_cnt1", {16'd0, scnt1}, g.sc1);
        check_eq("flush_cnt1", {16'd0, fcnt1}, g.fc1);
        check_eq("stall_cnt3", {16'd0, scnt3}, g.sc3);
        check_eq("flush_cnt3", {16'd0, fcnt3}, g.fc3);
`endif
        m_sc1 = cnt_upd(m_sc1, g.o1[2] && !g.o1[3] && !mw);
        m_fc1 = cnt_upd(m_fc1, g.o1[3]);
        m_sc3 = cnt_upd(m_sc3, g.o3[2] && !g.o3[3] && !mw);
        m_fc3 = cnt_upd(m_fc3, g.o3[3]);
        left1 = model_next(left1, 1, mw, bt, sr);
        left3 = model_next(left3, 3, mw, bt, sr);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_sc1"}, {26'd0, pcw1, ifw1, fl1, bub1, exw1, busy1}, {26'd0, IDLE});
        check_eq({tag, "_sc3"}, {26'd0, pcw3, ifw3, fl3, bub3, exw3, busy3}, {26'd0, IDLE});
`ifdef STALL_PERF_CNT_EN
        check_eq({tag, "_cnts"}, {scnt1 | fcnt1, scnt3 | fcnt3}, 32'd0);
`endif
    endtask

    task automatic model_reset();
        left1 = 0; left3 = 0;
        m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
    endtask

    initial begin
        rst_n = 1'b0; stall_req = 1'b0; branch_taken = 1'b0; mem_wait = 1'b0;
        #3;
        check_idle("in_reset");
        #4 rst_n = 1'b1;                       // release away from the clock edge
        // Idle after reset.
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        // Single load-use request.
        cyc(1'b0, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        // Stall then branch in the next cycle aborts it.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        // mem_wait freeze in the middle of a stall.
        cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        // Back-to-back requests, stall_req held high throughout.
        repeat (8) cyc(1'b0, 1'b0, 1'b1);
        // mem_wait wins over branch and stall.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        // Reset asserted mid-stall, asynchronously, with stall_req held high.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        stall_req = 1'b1;
        #1 check_eq("busy_before_rst", {31'd0, busy3}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check_idle("async_rst");
        model_reset();
        #3 stall_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 2) == 0));
        end
        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the load-use `stall` request from the hazard detector and the branch-taken signal from EX.
- Drives the pipeline-register write enables, the IF/ID flush and ID/EX bubble insertion.
- Supports multi-cycle load-use stalls (slow data memory) and a global memory-wait freeze.
- Sits between hazard detection / EX branch resolution and the PC, IF/ID and ID/EX registers.

Parameters:
- STALL_CYCLES, 1, bubble cycles inserted per load-use request; legal range 1..15.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall_req  input  1  load-use hazard request from the hazard detector.
- branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- mem_wait  input  1  data memory not ready; freezes the entire pipeline.
- pc_write  output  1  PC register write enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush  output  1  IF/ID loads a NOP this cycle.
- id_ex_bubble  output  1  ID/EX control fields forced to zero this cycle.
- id_ex_write  output  1  ID/EX register write enable.
- busy  output  1  high while in STALL state.
- stall_count  output  CNT_W  stall cycles counted (STALL_PERF_CNT_EN only).
- flush_count  output  CNT_W  flushes counted (STALL_PERF_CNT_EN only).

Behaviour:
- State is RUN or STALL, with a 4-bit remaining-cycle counter `rem`.
- Outputs are combinational from state and inputs, so a request affects the same cycle.
- Reset (async, rst_n=0): state=RUN, rem=0, counters=0.
- During reset, outputs hold the RUN-idle values: pc_write=1, if_id_write=1, id_ex_write=1, flush=0, bubble=0, busy=0.
- Priority within a cycle: mem_wait > branch_taken > stall_req.
- mem_wait=1, in any state:
  - pc_write=0, if_id_write=0, id_ex_write=0, flush=0, bubble=0.
  - State and rem are frozen.
  - branch_taken and stall_req are ignored that cycle; upstream holds them stable.
- branch_taken=1, mem_wait=0, in any state:
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, id_ex_write=1.
  - Next state is RUN, rem=0; this aborts any stall in progress.
- RUN, stall_req=1, no higher-priority event:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1.
  - If STALL_CYCLES>1: next state STALL, rem=STALL_CYCLES-1.
  - Otherwise remain in RUN.
- STALL, no higher-priority event:
  - Same outputs as a RUN stall cycle; busy=1.
  - rem decrements each cycle; at rem==1, next state is RUN.
  - stall_req is ignored while in STALL.
- RUN with no event: the idle values above.
- Total latency for one load-use request with no interference: exactly STALL_CYCLES bubble cycles, then PC advances on the next cycle.
- Back-to-back requests: a stall_req in the first RUN cycle after STALL starts a new stall sequence.
- Reset asserted mid-STALL: immediate return to RUN idle values, with no clock edge required.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - stall_count increments on every cycle with id_ex_bubble=1 and if_id_flush=0.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both counters saturate at 2^CNT_W-1, reset to 0, and do not count while mem_wait=1.
- Undefined: both ports are absent and no counter logic is synthesised.

Test Plan:
1. Reset release with all inputs at 0 -> pc_write=if_id_write=id_ex_write=1, flush=bubble=busy=0 from the first cycle.
2. STALL_CYCLES=1, stall_req pulsed for 1 cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; the next cycle is back to idle values; busy never rises.
3. STALL_CYCLES=3, stall_req pulsed at cycle 5 -> bubble=1 in cycles 5,6,7; busy=1 in cycles 6,7; pc_write=1 at cycle 8.
4. STALL_CYCLES=3, stall at cycle 5, branch_taken at cycle 6 -> cycle 6 has flush=1, bubble=1, pc_write=1; cycle 7 has idle values (stall aborted).
5. mem_wait=1 for cycles 6-8 during a 3-cycle stall -> all write enables 0 in cycles 6-8; stall resumes and finishes with bubbles in cycles 9,10; pc_write=1 at cycle 11.
6. rst_n driven low mid-STALL, asynchronous to clk -> outputs return to idle values immediately; with STALL_PERF_CNT_EN defined, both counters read 0.
